// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and types for the four-requester round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ     = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 16;

    // Reset value of the last-grant pointer; makes the first scan start at index 0.
    localparam logic [SEL_W-1:0] RST_LAST = 2'd3;

    // The output register's valid bit is the whole state.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/MUX64_16.sv
// Shared 4:1 data mux: four WIDTH-bit words in, one selected word out.
module MUX64_16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       S,
    output logic [WIDTH-1:0] DO
);

    always_comb begin
        DO = A;
        case (S)
            2'd0:    DO = A;
            2'd1:    DO = B;
            2'd2:    DO = C;
            default: DO = D;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin picker: first set request bit scanning upward from last+1 with wrap.
module rr_pick4
    import mux4_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] last,
    output logic             any,
    output logic [SEL_W-1:0] w
);

    logic [SEL_W-1:0] idx;

    // Walk from the lowest priority (last itself) up to last+1 so the nearest hit wins.
    always_comb begin
        any = 1'b0;
        w   = '0;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + SEL_W'(k);
            if (req[idx]) begin
                any = 1'b1;
                w   = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the shared 4:1 mux select, with a registered
// valid/ready output stage that sustains one word per clock.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    output logic [N_REQ-1:0] ack,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    logic             any;
    logic [SEL_W-1:0] w;
    logic [WIDTH-1:0] mux_do;
    logic             valid;
    logic             cap;
    logic             xfer;

    rr_pick4 u_pick (
        .req  (req),
        .last (last_q),
        .any  (any),
        .w    (w)
    );

    MUX64_16 #(.WIDTH(WIDTH)) u_mux (
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (D),
        .S  (w),
        .DO (mux_do)
    );

    assign valid = (state_q == ST_HOLD);
    // Gating with rst_n keeps ack low (and X on req harmless) during reset.
    assign cap   = rst_n & any & (~valid | out_ready);
    assign xfer  = valid & out_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        last_d     = last_q;
        xfer_cnt_d = xfer_cnt_q + {{(CNT_W-1){1'b0}}, xfer};
        ack        = '0;
        if (cap) begin
            ack        = sel_onehot(w);
            state_d    = ST_HOLD;
            out_data_d = mux_do;
            out_sel_d  = w;
            last_d     = w;
        end else if (xfer) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            out_data_q <= '0;
            out_sel_q  <= '0;
            last_q     <= RST_LAST;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_sel_q  <= out_sel_d;
            last_q     <= last_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = valid;
    assign busy      = valid;
    assign xfer_cnt  = xfer_cnt_q;

endmodule
